// File: rtl/blink_pattern_sequencer_if.sv
// Control/config/blinker-drive bundle between the controller logic (master)
// and the blink pattern sequencer (slave).
interface blink_pattern_sequencer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          start;
  logic          stop;
  logic          loop_en;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_data;
  logic          cfg_err;
  logic          enable;
  logic          switch_1;
  logic          switch_2;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;

  modport master (
    output start, stop, loop_en, cfg_we, cfg_addr, cfg_data,
    input  cfg_err, enable, switch_1, switch_2, busy, done, step
  );

  modport slave (
    input  start, stop, loop_en, cfg_we, cfg_addr, cfg_data,
    output cfg_err, enable, switch_1, switch_2, busy, done, step
  );
endinterface

// File: rtl/blink_pattern_sequencer.sv
// Steps the LED blinker through a programmable table of {on, rate sel, ms}
// entries, inserting an enable-low gap between entries.
module blink_pattern_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TICK_DIV   = 25,
  parameter int unsigned GAP_CYCLES = 10,
  parameter int unsigned DUR_W      = 13
) (
  input  logic                     clock,
  input  logic                     reset,
  blink_pattern_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_GAP, S_END} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0][15:0] table_q, table_d;
  logic [AW-1:0]          step_q, step_d;
  logic [PW-1:0]          pre_q, pre_d;
  logic [DUR_W-1:0]       ms_q, ms_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   en_q, en_d;
  logic                   sw1_q, sw1_d;
  logic                   sw2_q, sw2_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [15:0]      cur_entry;
  logic [DUR_W-1:0] cur_dur;

  assign cur_entry = table_q[step_q];
  assign cur_dur   = DUR_W'(cur_entry[12:0]);

  always_comb begin
    state_d = state_q;
    table_d = table_q;
    step_d  = step_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    gap_d   = gap_q;
    en_d    = en_q;
    sw1_d   = sw1_q;
    sw2_d   = sw2_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Table is only writable while idle; otherwise flag the dropped write.
    if (bus.cfg_we) begin
      if (state_q == S_IDLE) table_d[bus.cfg_addr] = bus.cfg_data;
      else                   err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_FETCH;
          step_d  = '0;
        end
      end
      S_FETCH: begin
        if (cur_dur == '0) begin
          state_d = S_END;
        end else begin
          state_d = S_RUN;
          en_d    = cur_entry[15];
          sw1_d   = cur_entry[14];
          sw2_d   = cur_entry[13];
          pre_d   = '0;
          ms_d    = cur_dur;
        end
      end
      S_RUN: begin
        if (pre_q == PW'(TICK_DIV - 1)) begin
          pre_d = '0;
          ms_d  = ms_q - DUR_W'(1);
          if (ms_q == DUR_W'(1)) begin
            state_d = S_GAP;
            en_d    = 1'b0;
            gap_d   = '0;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (step_q == AW'(DEPTH - 1)) begin
            state_d = S_END;
          end else begin
            state_d = S_FETCH;
            step_d  = step_q + AW'(1);
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_END: begin
        // step 0 here can only mean an end marker at entry 0: never loop on it.
        if (bus.loop_en && step_q != '0) begin
          state_d = S_FETCH;
          step_d  = '0;
        end else begin
          state_d = S_IDLE;
          step_d  = '0;
          done_d  = 1'b1;
          en_d    = 1'b0;
          sw1_d   = 1'b0;
          sw2_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      step_d  = '0;
      en_d    = 1'b0;
      sw1_d   = 1'b0;
      sw2_d   = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      table_q <= '0;
      step_q  <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      sw1_q   <= 1'b0;
      sw2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      sw1_q   <= sw1_d;
      sw2_q   <= sw2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.enable   = en_q;
  assign bus.switch_1 = sw1_q;
  assign bus.switch_2 = sw2_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_err  = err_q;
  assign bus.step     = step_q;

endmodule

// File: tb/tb_blink_pattern_sequencer.sv
// Bench for blink_pattern_sequencer: a table-level timeline model predicts
// every output cycle by cycle after each start pulse.
module tb_blink_pattern_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TICK  = 25;
  localparam int unsigned GAP   = 10;
  localparam int unsigned AW    = 3;

  localparam int P_NONE  = 0;
  localparam int P_STOP  = 1;
  localparam int P_WRITE = 2;
  localparam int P_START = 3;
  localparam int P_RESET = 4;

  typedef struct packed {
    logic          en;
    logic          s1;
    logic          s2;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] step;
  } obs_t;

  logic clock = 1'b0;
  logic reset;

  blink_pattern_sequencer_if #(.DEPTH(DEPTH)) bus ();

  blink_pattern_sequencer #(
    .DEPTH(DEPTH), .TICK_DIV(TICK), .GAP_CYCLES(GAP), .DUR_W(13)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] tbl_m [DEPTH];
  obs_t        exp_q [$];
  int          n_cmp;
  int          n_err;
  int          done_idx;
  int          en_cnt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.en   = bus.enable;
    o.s1   = bus.switch_1;
    o.s2   = bus.switch_2;
    o.busy = bus.busy;
    o.done = bus.done;
    o.err  = bus.cfg_err;
    o.step = bus.step;
    return o;
  endfunction

  function automatic obs_t mk(input logic en, input logic s1, input logic s2,
                              input logic busy, input logic done, input int k);
    obs_t o;
    o.en = en; o.s1 = s1; o.s2 = s2; o.busy = busy; o.done = done;
    o.err = 1'b0; o.step = AW'(k);
    return o;
  endfunction

  // Timeline from the table: FETCH, dur*TICK run, GAP gap, END, done, idle.
  task automatic build_trace(input bit lp, input int maxlen);
    int   k;
    int   d;
    logic s1, s2, on;
    exp_q.delete();
    k = 0; s1 = 1'b0; s2 = 1'b0;
    while (exp_q.size() < maxlen) begin
      d = int'(tbl_m[k][12:0]);
      exp_q.push_back(mk(1'b0, s1, s2, 1'b1, 1'b0, k));
      if (d != 0) begin
        on = tbl_m[k][15]; s1 = tbl_m[k][14]; s2 = tbl_m[k][13];
        repeat (d * TICK) exp_q.push_back(mk(on, s1, s2, 1'b1, 1'b0, k));
        repeat (GAP)      exp_q.push_back(mk(1'b0, s1, s2, 1'b1, 1'b0, k));
      end
      if (d == 0 || k == DEPTH - 1) begin
        exp_q.push_back(mk(1'b0, s1, s2, 1'b1, 1'b0, k));
        if (lp && !(d == 0 && k == 0)) begin
          k = 0;
        end else begin
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
          break;
        end
      end else begin
        k++;
      end
    end
  endtask

  task automatic program_entry(input int addr, input logic [15:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
    tbl_m[addr]  = data;
    n_cmp++;
    if (bus.cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL idle_write_err addr=%0d: got cfg_err=%b, expected 0", addr, bus.cfg_err);
    end
  endtask

  // Pulse start, then compare every cycle against the model, applying one poke.
  task automatic run_seq(input bit lp, input int maxlen, input int pk,
                         input int pk_at, input string name);
    obs_t o;
    obs_t e;
    build_trace(lp, maxlen);
    if (pk == P_STOP || pk == P_RESET) begin
      while (exp_q.size() > pk_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    if (pk == P_WRITE) begin
      e = exp_q[pk_at + 1];
      e.err = 1'b1;
      exp_q[pk_at + 1] = e;
    end
    bus.loop_en = lp;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    done_idx  = -1;
    en_cnt    = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = sample();
      e = exp_q[i];
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got en=%b sw=%b%b busy=%b done=%b err=%b step=%0d, expected en=%b sw=%b%b busy=%b done=%b err=%b step=%0d",
                 name, i, o.en, o.s1, o.s2, o.busy, o.done, o.err, o.step,
                 e.en, e.s1, e.s2, e.busy, e.done, e.err, e.step);
      end
      if (o.done === 1'b1 && done_idx < 0) done_idx = i;
      if (o.en === 1'b1) en_cnt++;
      bus.stop   = (pk == P_STOP  && i == pk_at);
      bus.start  = (pk == P_START && i == pk_at);
      reset      = (pk == P_RESET && i == pk_at);
      bus.cfg_we = (pk == P_WRITE && i == pk_at);
      if (pk == P_WRITE && i == pk_at) begin
        bus.cfg_addr = AW'($urandom);
        bus.cfg_data = 16'($urandom);
      end
      tick();
    end
    bus.stop = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0; reset = 1'b0;
    if (pk == P_RESET) for (int j = 0; j < DEPTH; j++) tbl_m[j] = 16'h0000;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; bus.start = 1'b1; bus.cfg_we = 1'b1;
    tick(); tick();
    o = sample();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected all 0", o);
    end
    reset = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0;
    tick();
    o = sample();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b, expected all 0", o);
    end
  endtask

  task automatic test_single_entry();
    program_entry(0, 16'hA002);
    program_entry(1, 16'h0000);
    run_seq(1'b0, 5000, P_NONE, 0, "single_entry");
    n_cmp++;
    if (done_idx !== 63) begin
      n_err++;
      $display("FAIL single_done_time: got %0d, expected 63", done_idx);
    end
    n_cmp++;
    if (en_cnt !== 50) begin
      n_err++;
      $display("FAIL single_enable_len: got %0d, expected 50", en_cnt);
    end
  endtask

  task automatic load_full_table();
    for (int k = 0; k < DEPTH; k++) program_entry(k, {1'b1, 2'(k % 4), 13'd1});
  endtask

  task automatic test_full_table();
    load_full_table();
    run_seq(1'b0, 5000, P_NONE, 0, "full_table");
    n_cmp++;
    if (done_idx !== 289) begin
      n_err++;
      $display("FAIL full_done_time: got %0d, expected 289", done_idx);
    end
    n_cmp++;
    if (en_cnt !== 200) begin
      n_err++;
      $display("FAIL full_enable_cycles: got %0d, expected 200", en_cnt);
    end
  endtask

  task automatic test_loop_stop();
    run_seq(1'b1, 700, P_STOP, 370, "loop_stop");
    n_cmp++;
    if (done_idx !== -1) begin
      n_err++;
      $display("FAIL loop_no_done: got done at %0d, expected none", done_idx);
    end
  endtask

  task automatic test_start_during_run();
    run_seq(1'b0, 5000, P_START, 10, "start_in_run");
    n_cmp++;
    if (done_idx !== 289) begin
      n_err++;
      $display("FAIL restart_ignored_done: got %0d, expected 289", done_idx);
    end
  endtask

  task automatic test_start_stop_idle();
    obs_t o;
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      o = sample();
      n_cmp++;
      if (o !== obs_t'(0)) begin
        n_err++;
        $display("FAIL start_stop_idle cycle %0d: got %b, expected all 0", i, o);
      end
      tick();
    end
  endtask

  task automatic load_random_table(input bit allow_marker);
    int d;
    for (int k = 0; k < DEPTH; k++) begin
      d = (allow_marker && $urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2));
      program_entry(k, {1'($urandom), 2'($urandom), 13'(d)});
    end
  endtask

  task automatic test_cfg_err();
    load_random_table(1'b0);
    run_seq(1'b0, 5000, P_WRITE, 5, "cfg_err_write");
    run_seq(1'b0, 5000, P_NONE, 0, "cfg_err_replay");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      load_random_table(1'b1);
      run_seq(1'b0, 5000, P_NONE, 0, "random_table");
    end
  endtask

  task automatic test_reset_in_gap();
    program_entry(0, 16'hA002);
    program_entry(1, 16'h0000);
    run_seq(1'b0, 5000, P_RESET, 55, "reset_in_gap");
    run_seq(1'b1, 5000, P_NONE, 0, "after_reset");
    n_cmp++;
    if (done_idx !== 2) begin
      n_err++;
      $display("FAIL cleared_table_done: got %0d, expected 2", done_idx);
    end
    n_cmp++;
    if (en_cnt !== 0) begin
      n_err++;
      $display("FAIL cleared_table_enable: got %0d, expected 0", en_cnt);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    for (int j = 0; j < DEPTH; j++) tbl_m[j] = 16'h0000;
    test_reset();
    test_single_entry();
    test_full_table();
    test_loop_stop();
    test_start_during_run();
    test_start_stop_idle();
    test_cfg_err();
    test_random();
    test_reset_in_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
